// File: rtl/partition_tt_sweeper_pkg.sv
// partition_tt_pkg: shared types and constants for the truth-table sweeper.
//   tt_state_t   : sweeper FSM state encoding
//   TT_SIG_W     : width of the running signature
//   TT_MAX_W     : upper bound for N_IN and N_OUT
//   tt_sig_next  : one rotate-left-by-one / XOR signature step
package partition_tt_pkg;

   localparam int TT_SIG_W = 16;
   localparam int TT_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } tt_state_t;

   function automatic logic [TT_SIG_W-1:0] tt_sig_next(
      input logic [TT_SIG_W-1:0] sig_cur,
      input logic [TT_SIG_W-1:0] data
   );
      return {sig_cur[TT_SIG_W-2:0], sig_cur[TT_SIG_W-1]} ^ data;
   endfunction

endpackage

// File: rtl/partition_tt_sweeper_signature.sv
// tt_signature: rotate-XOR accumulator over the emitted rows.
// Ports:
//   clk  in        rising-edge clock
//   rst  in        synchronous active-high reset
//   clr  in        clear the signature (a new sweep starts)
//   en   in        fold data into the signature (a row handshake)
//   data in DATA_W row data, zero-extended to TT_SIG_W
//   sig  out 16    running signature
module tt_signature
   import partition_tt_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic [DATA_W-1:0]   data,
   output logic [TT_SIG_W-1:0] sig
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= tt_sig_next(sig, TT_SIG_W'(data));
      end
   end

endmodule

// File: rtl/partition_tt_sweeper.sv
// partition_tt_sweeper: exhaustive truth-table sweeper for a combinational
// partition. Drives every pattern 0 .. 2^N_IN-1 on pi, waits SETTLE cycles,
// captures po and streams (index, data) rows over a valid/ready handshake.
// Optional feature macro: PARTITION_TT_SIG_EN adds the 16-bit running
// signature output sig.
// Ports:
//   clk       in         rising-edge clock
//   rst       in         synchronous active-high reset
//   start     in         begin a sweep (only looked at in IDLE)
//   busy      out        high in WAIT and EMIT
//   done      out        one-cycle pulse after the last row handshake
//   pi        out N_IN   pattern driven to the partition
//   po        in  N_OUT  partition response
//   row_valid out        row available
//   row_ready in         consumer accepts the row
//   row_index out N_IN   pattern that produced row_data
//   row_data  out N_OUT  captured po
//   sig       out 16     running signature (PARTITION_TT_SIG_EN only)
//
// state | meaning
// IDLE  | waiting for start; pi keeps its last value
// WAIT  | pi held, settle down-counter running; capture po at terminal count
// EMIT  | row_valid high, row held until row_ready
// DONE  | done pulse, back to IDLE next cycle
module partition_tt_sweeper
   import partition_tt_pkg::*;
#(
   parameter int N_IN   = 7,
   parameter int N_OUT  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [N_IN-1:0]  pi,
   input  logic [N_OUT-1:0] po,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [N_IN-1:0]  row_index,
   output logic [N_OUT-1:0] row_data
`ifdef PARTITION_TT_SIG_EN
   ,
   output logic [TT_SIG_W-1:0] sig
`endif
);

   // Counter only has to hold SETTLE-1.
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  PI_LAST  = '1;

   tt_state_t        state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pi        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         row_valid <= 1'b0;
         row_index <= '0;
         row_data  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pi    <= '0;
                  cnt   <= CNT_LOAD;
                  busy  <= 1'b1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  row_data  <= po;
                  row_index <= pi;
                  row_valid <= 1'b1;
                  state     <= EMIT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            EMIT: begin
               // row_valid is always high here, so row_ready alone completes the handshake.
               if (row_ready) begin
                  row_valid <= 1'b0;
                  if (pi == PI_LAST) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     pi    <= pi + N_IN'(1);
                     cnt   <= CNT_LOAD;
                     state <= WAIT;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PARTITION_TT_SIG_EN
   logic sig_clr;
   logic sig_en;

   assign sig_clr = (state == IDLE) && start;
   assign sig_en  = (state == EMIT) && row_ready;

   tt_signature #(
      .DATA_W (N_OUT)
   ) u_signature (
      .clk  (clk),
      .rst  (rst),
      .clr  (sig_clr),
      .en   (sig_en),
      .data (row_data),
      .sig  (sig)
   );
`endif

endmodule

// File: tb/tb_partition_tt_sweeper.sv
// Bench for partition_tt_sweeper. Four instances share clk/rst:
//   A: N_IN=3 N_OUT=2 SETTLE=1, po = popcount(pi)
//   B: N_IN=3 N_OUT=2 SETTLE=3, po = popcount(pi) delayed by 2 cycles
//   C: N_IN=7 N_OUT=4 SETTLE=1, po = pi[6:4] + pi[3:0] (4-bit)
//   D: N_IN=3 N_OUT=2 SETTLE=1, po = popcount(pi) delayed by 2 cycles
// Optional: PARTITION_TT_SIG_EN (sig port and signature checks).
module tb_partition_tt_sweeper;

   logic clk = 1'b0;
   logic rst;
   logic g_start;
   logic g_ready;
   int   sel;

   always #5 clk = ~clk;

   function automatic logic [1:0] pc3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

   // A
   logic       a_start, a_busy, a_done, a_valid;
   logic [2:0] a_pi, a_idx;
   logic [1:0] a_po, a_data;
   // B
   logic       b_start, b_busy, b_done, b_valid;
   logic [2:0] b_pi, b_idx;
   logic [1:0] b_po, b_data, b_d1, b_d2;
   // C
   logic       c_start, c_busy, c_done, c_valid;
   logic [6:0] c_pi, c_idx;
   logic [3:0] c_po, c_data;
   // D
   logic       d_start, d_busy, d_done, d_valid;
   logic [2:0] d_pi, d_idx;
   logic [1:0] d_po, d_data, d_d1, d_d2;
`ifdef PARTITION_TT_SIG_EN
   logic [15:0] a_sig, b_sig, c_sig, d_sig, cur_sig;
`endif

   assign a_start = g_start && (sel == 0);
   assign b_start = g_start && (sel == 1);
   assign c_start = g_start && (sel == 2);
   assign d_start = g_start && (sel == 3);

   assign a_po = pc3(a_pi);
   assign c_po = 4'(c_pi[6:4]) + c_pi[3:0];
   always_ff @(posedge clk) begin
      b_d1 <= pc3(b_pi);
      b_d2 <= b_d1;
      d_d1 <= pc3(d_pi);
      d_d2 <= d_d1;
   end
   assign b_po = b_d2;
   assign d_po = d_d2;

   partition_tt_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
      .pi(a_pi), .po(a_po), .row_valid(a_valid), .row_ready(g_ready),
      .row_index(a_idx), .row_data(a_data)
`ifdef PARTITION_TT_SIG_EN
      , .sig(a_sig)
`endif
   );

   partition_tt_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .pi(b_pi), .po(b_po), .row_valid(b_valid), .row_ready(g_ready),
      .row_index(b_idx), .row_data(b_data)
`ifdef PARTITION_TT_SIG_EN
      , .sig(b_sig)
`endif
   );

   partition_tt_sweeper #(.N_IN(7), .N_OUT(4), .SETTLE(1)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
      .pi(c_pi), .po(c_po), .row_valid(c_valid), .row_ready(g_ready),
      .row_index(c_idx), .row_data(c_data)
`ifdef PARTITION_TT_SIG_EN
      , .sig(c_sig)
`endif
   );

   partition_tt_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_d (
      .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
      .pi(d_pi), .po(d_po), .row_valid(d_valid), .row_ready(g_ready),
      .row_index(d_idx), .row_data(d_data)
`ifdef PARTITION_TT_SIG_EN
      , .sig(d_sig)
`endif
   );

   // View of the instance currently under test.
   logic        cur_busy, cur_done, cur_valid;
   logic [15:0] cur_pi, cur_idx, cur_data;

   always_comb begin
      cur_busy  = 1'b0;
      cur_done  = 1'b0;
      cur_valid = 1'b0;
      cur_pi    = '0;
      cur_idx   = '0;
      cur_data  = '0;
`ifdef PARTITION_TT_SIG_EN
      cur_sig   = '0;
`endif
      case (sel)
         0: begin
            cur_busy = a_busy; cur_done = a_done; cur_valid = a_valid;
            cur_pi = 16'(a_pi); cur_idx = 16'(a_idx); cur_data = 16'(a_data);
`ifdef PARTITION_TT_SIG_EN
            cur_sig = a_sig;
`endif
         end
         1: begin
            cur_busy = b_busy; cur_done = b_done; cur_valid = b_valid;
            cur_pi = 16'(b_pi); cur_idx = 16'(b_idx); cur_data = 16'(b_data);
`ifdef PARTITION_TT_SIG_EN
            cur_sig = b_sig;
`endif
         end
         2: begin
            cur_busy = c_busy; cur_done = c_done; cur_valid = c_valid;
            cur_pi = 16'(c_pi); cur_idx = 16'(c_idx); cur_data = 16'(c_data);
`ifdef PARTITION_TT_SIG_EN
            cur_sig = c_sig;
`endif
         end
         default: begin
            cur_busy = d_busy; cur_done = d_done; cur_valid = d_valid;
            cur_pi = 16'(d_pi); cur_idx = 16'(d_idx); cur_data = 16'(d_data);
`ifdef PARTITION_TT_SIG_EN
            cur_sig = d_sig;
`endif
         end
      endcase
   end

   typedef struct {
      int idx;
      int data;
   } row_t;

   row_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Independent reference for each bench partition.
   function automatic int exp_data(input int s, input int idx);
      int ones;
      if (s == 2) return (((idx >> 4) & 7) + (idx & 15)) % 16;
      ones = 0;
      for (int b = 0; b < 3; b++) if ((idx >> b) & 1) ones++;
      return ones;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  32'(cur_busy), 0);
      check({tag, "_done"},  32'(cur_done), 0);
      check({tag, "_valid"}, 32'(cur_valid), 0);
      check({tag, "_index"}, 32'(cur_idx), 0);
      check({tag, "_data"},  32'(cur_data), 0);
      check({tag, "_pi"},    32'(cur_pi), 0);
`ifdef PARTITION_TT_SIG_EN
      check({tag, "_sig"},   32'(cur_sig), 0);
`endif
   endtask

   // One sweep on instance s. stall_idx: hold row_ready low 5 cycles on that row.
   // abort_idx: assert rst while that row is offered. poke: pulse start during EMIT.
   // exact=0: rows are expected to be stale, count data differences instead.
   task automatic run_sweep(input int s, input int n_rows, input int settle, input int exp_k,
                            input int stall_idx, input int abort_idx, input bit poke,
                            input bit exact);
      int   k, rows, diffs, first_v, extra_done;
      bit   got_done, stalled;
      row_t r;
      logic [15:0] sig_model;

      sel = s;
      q.delete();
      for (int i = 0; i < n_rows; i++) q.push_back('{idx: i, data: exp_data(s, i)});
      k = 0; rows = 0; diffs = 0; first_v = -1; got_done = 0; stalled = 0;
      sig_model = '0;

      g_start = 1'b1;
      tick();
      g_start = 1'b0;
      check("start_pi_zero", 32'(cur_pi), 0);
      check("start_busy", 32'(cur_busy), 1);
`ifdef PARTITION_TT_SIG_EN
      if (s == 0) check("start_sig_clear", 32'(cur_sig), 0);
`endif

      while (!got_done && k < exp_k + 50) begin
         if (cur_valid && first_v < 0) first_v = k;
         if (cur_valid && g_ready) begin
            if (int'(cur_idx) == abort_idx) begin
               rst = 1'b1;
               tick();
               check_reset_outputs("abort");
               rst = 1'b0;
               q.delete();
               return;
            end
            if (int'(cur_idx) == stall_idx && !stalled) begin
               stalled = 1'b1;
               g_ready = 1'b0;
               repeat (5) begin
                  tick();
                  k++;
                  check("stall_valid", 32'(cur_valid), 1);
                  check("stall_index", 32'(cur_idx), 32'(stall_idx));
                  check("stall_data", 32'(cur_data), 32'(exp_data(s, stall_idx)));
                  check("stall_pi", 32'(cur_pi), 32'(stall_idx));
               end
               g_ready = 1'b1;
            end
            if (q.size() == 0) begin
               check("extra_row", 32'(rows), 32'(n_rows - 1));
            end else begin
               r = q.pop_front();
               check("row_index", 32'(cur_idx), 32'(r.idx));
               if (exact) check("row_data", 32'(cur_data), 32'(r.data));
               else if (int'(cur_data) != r.data) diffs++;
            end
            rows++;
            sig_model = {sig_model[14:0], sig_model[15]} ^ cur_data;
            if (poke && rows == 1) g_start = 1'b1;
         end
         tick();
         k++;
         g_start = 1'b0;
         if (cur_done) got_done = 1'b1;
      end

      check("done_seen", 32'(got_done), 1);
      check("done_cycle", 32'(k), 32'(exp_k));
      check("busy_at_done", 32'(cur_busy), 0);
      check("row_count", 32'(rows), 32'(n_rows));
      check("queue_empty", 32'(q.size()), 0);
      check("first_valid_cycle", 32'(first_v), 32'(settle));
      if (!exact) check("stale_rows_seen", 32'(diffs != 0), 1);
`ifdef PARTITION_TT_SIG_EN
      if (s == 0) check("signature", 32'(cur_sig), 32'(sig_model));
`endif
      tick();
      check("done_one_cycle", 32'(cur_done), 0);
      check("pi_holds_last", 32'(cur_pi), 32'(n_rows - 1));
      extra_done = 0;
      repeat (3) begin
         tick();
         if (cur_done) extra_done++;
      end
      check("no_extra_done", 32'(extra_done), 0);
`ifdef PARTITION_TT_SIG_EN
      if (s == 0) check("signature_hold", 32'(cur_sig), 32'(sig_model));
`endif
   endtask

   initial begin
      rst     = 1'b1;
      g_start = 1'b0;
      g_ready = 1'b1;
      sel     = 0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // basic sweep (and signature)
      run_sweep(0, 8, 1, 16, -1, -1, 1'b0, 1'b1);
      // backpressure on row 3; also checks a second start clears sig
      run_sweep(0, 8, 1, 21, 3, -1, 1'b0, 1'b1);
      // reset while row 4 is offered
      run_sweep(0, 8, 1, 0, -1, 4, 1'b0, 1'b1);
      tick();
      // fresh sweep restarts at 0; a start during EMIT is ignored
      run_sweep(0, 8, 1, 16, -1, -1, 1'b1, 1'b1);
      // long settle covers a 2-cycle partition delay
      run_sweep(1, 8, 3, 32, -1, -1, 1'b0, 1'b1);
      // short settle with the same delay samples stale data
      run_sweep(3, 8, 1, 16, -1, -1, 1'b0, 1'b0);
      // 7-bit sweep of the 4-bit adder
      run_sweep(2, 128, 1, 256, -1, -1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
